dsa_step_controller: RTL and testbench

Host-side stepping controller for the bilinear-interpolation DSA debug path. It decodes JTAG host register writes into halt, resume and step commands, and gates the DSA datapath through a clock-enable. It also matches coordinate breakpoints and drives the `capture_enable` / `step_ack` pair consumed by the debug-register capture block. Its `status` word is presented to JTAG alongside the captured debug registers.

---
 rtl/dsa_step_controller_pkg.sv | 24 ++
 rtl/dsa_step_controller_if.sv | 10 +
 rtl/dsa_step_controller_bp_match.sv | 13 +
 rtl/dsa_step_controller.sv | 165 ++++++++++++++++
 tb/tb_dsa_step_controller.sv | 228 ++++++++++++++++++++++
 5 files changed

// File: rtl/dsa_step_controller_pkg.sv
// Shared types and constants for the DSA debug stepping path: FSM state
// encoding, CTRL bit positions and host register addresses.
package dsa_debug_pkg;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    HALTED = 2'd1,
    STEP   = 2'd2,
    ACK    = 2'd3
  } step_state_t;

  localparam int CTRL_DEBUG_EN  = 0;
  localparam int CTRL_HALT      = 1;
  localparam int CTRL_RESUME    = 2;
  localparam int CTRL_STEP      = 3;
  localparam int CTRL_STEP_MODE = 4;
  localparam int CTRL_BP_EN     = 5;
  localparam int CTRL_CLR_BP    = 6;

  localparam logic [1:0] ADDR_CTRL       = 2'd0;
  localparam logic [1:0] ADDR_STEP_COUNT = 2'd1;
  localparam logic [1:0] ADDR_BP         = 2'd2;

endpackage

// File: rtl/dsa_step_controller_if.sv
// Host register-write bus from the JTAG side into the stepping controller.
interface dsa_step_controller_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [1:0]  cmd_addr;
  logic [31:0] cmd_wdata;

  modport master (output cmd_valid, output cmd_addr, output cmd_wdata, input cmd_ready);
  modport slave  (input cmd_valid, input cmd_addr, input cmd_wdata, output cmd_ready);
endinterface

// File: rtl/dsa_step_controller_bp_match.sv
// Purely combinational coordinate breakpoint comparator; a hit is only
// meaningful on a cycle where the DSA retires an output pixel.
module dsa_bp_match (
  input  logic        pixel_done,
  input  logic        bp_en,
  input  logic [15:0] current_x,
  input  logic [15:0] current_y,
  input  logic [15:0] bp_x,
  input  logic [15:0] bp_y,
  output logic        hit
);
  assign hit = bp_en && pixel_done && (current_x == bp_x) && (current_y == bp_y);
endmodule

// File: rtl/dsa_step_controller.sv
// Host-side halt/resume/step controller gating the DSA datapath clock-enable
// and producing the capture pulse for the debug-register snapshot block.
module dsa_step_controller
  import dsa_debug_pkg::*;
#(
  parameter int CNT_WIDTH = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  dsa_step_controller_if.slave       cmd,
  input  logic                       pixel_done,
  input  logic                       dsa_done,
  input  logic [15:0]                current_x,
  input  logic [15:0]                current_y,
  output logic                       dsa_advance,
  output logic                       capture_enable,
  output logic                       step_ack,
  output logic                       halted,
  output logic [31:0]                status
);

  step_state_t          state_q, state_d;
  logic [CNT_WIDTH-1:0] rem_q, rem_d;
  logic [CNT_WIDTH-1:0] step_count_q;
  logic [15:0]          bp_x_q, bp_y_q;
  logic                 debug_en_q, step_mode_q, bp_en_q;
  logic                 halt_q, resume_q, step_q, clr_bp_q;
  logic                 bp_hit_q, bp_hit_d;
  logic                 done_seen_q, done_seen_d;
  logic                 bp_match;
  logic                 dec;
  logic [15:0]          rem16;

  function automatic logic [CNT_WIDTH-1:0] sat_dec(input logic [CNT_WIDTH-1:0] v);
    return (v == '0) ? '0 : v - CNT_WIDTH'(1);
  endfunction

  function automatic logic [CNT_WIDTH-1:0] at_least_one(input logic [CNT_WIDTH-1:0] v);
    return (v == '0) ? CNT_WIDTH'(1) : v;
  endfunction

  assign cmd.cmd_ready = 1'b1;

  dsa_bp_match u_bp_match (
    .pixel_done (pixel_done),
    .bp_en      (bp_en_q),
    .current_x  (current_x),
    .current_y  (current_y),
    .bp_x       (bp_x_q),
    .bp_y       (bp_y_q),
    .hit        (bp_match)
  );

  // Command stage: host writes land here; pulse bits live for one cycle so
  // the FSM sees them together with the freshly written debug_en.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      debug_en_q   <= 1'b0;
      step_mode_q  <= 1'b0;
      bp_en_q      <= 1'b0;
      halt_q       <= 1'b0;
      resume_q     <= 1'b0;
      step_q       <= 1'b0;
      clr_bp_q     <= 1'b0;
      step_count_q <= '0;
      bp_x_q       <= '0;
      bp_y_q       <= '0;
    end else begin
      halt_q   <= 1'b0;
      resume_q <= 1'b0;
      step_q   <= 1'b0;
      clr_bp_q <= 1'b0;
      if (cmd.cmd_valid) begin
        case (cmd.cmd_addr)
          ADDR_CTRL: begin
            debug_en_q  <= cmd.cmd_wdata[CTRL_DEBUG_EN];
            halt_q      <= cmd.cmd_wdata[CTRL_HALT];
            resume_q    <= cmd.cmd_wdata[CTRL_RESUME];
            step_q      <= cmd.cmd_wdata[CTRL_STEP];
            step_mode_q <= cmd.cmd_wdata[CTRL_STEP_MODE];
            bp_en_q     <= cmd.cmd_wdata[CTRL_BP_EN];
            clr_bp_q    <= cmd.cmd_wdata[CTRL_CLR_BP];
          end
          ADDR_STEP_COUNT: step_count_q <= cmd.cmd_wdata[CNT_WIDTH-1:0];
          ADDR_BP: begin
            bp_x_q <= cmd.cmd_wdata[15:0];
            bp_y_q <= cmd.cmd_wdata[31:16];
          end
          default: ;
        endcase
      end
    end
  end

  assign dec = step_mode_q ? pixel_done : 1'b1;

  always_comb begin
    state_d     = state_q;
    rem_d       = rem_q;
    bp_hit_d    = bp_hit_q;
    done_seen_d = done_seen_q;
    if (clr_bp_q) bp_hit_d = 1'b0;
    if (resume_q) done_seen_d = 1'b0;
    if (!debug_en_q) begin
      state_d = RUN;
    end else begin
      case (state_q)
        RUN: begin
          if (halt_q || bp_match) state_d = ACK;
          if (bp_match) bp_hit_d = 1'b1;
        end
        HALTED: begin
          if (step_q) begin
            state_d = STEP;
            rem_d   = at_least_one(step_count_q);
          end else if (resume_q) begin
            state_d = RUN;
          end
        end
        STEP: begin
          // A halt freezes the count where it stands.
          if (halt_q) begin
            state_d = ACK;
          end else if (dec) begin
            if (rem_q <= CNT_WIDTH'(1)) state_d = ACK;
            rem_d = sat_dec(rem_q);
          end
          if (dsa_done) begin
            state_d     = ACK;
            done_seen_d = 1'b1;
          end
          if (bp_match) begin
            state_d  = ACK;
            bp_hit_d = 1'b1;
          end
        end
        ACK:     state_d = HALTED;
        default: state_d = RUN;
      endcase
    end
  end

  // FSM stage
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= RUN;
      rem_q       <= '0;
      bp_hit_q    <= 1'b0;
      done_seen_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      rem_q       <= rem_d;
      bp_hit_q    <= bp_hit_d;
      done_seen_q <= done_seen_d;
    end
  end

  assign rem16          = 16'(rem_q);
  assign dsa_advance    = (state_q == RUN) || (state_q == STEP);
  assign step_ack       = (state_q == ACK);
  assign halted         = (state_q == HALTED);
  assign capture_enable = debug_en_q;
  assign status         = {rem16, 11'd0, done_seen_q, bp_hit_q, step_mode_q, 2'(state_q)};

endmodule

// File: tb/tb_dsa_step_controller.sv
// Directed bench for dsa_step_controller: expected per-cycle output vectors
// are queued by the stimulus and checked by an independent negedge monitor.
module tb_dsa_step_controller;

  logic        clk = 1'b0;
  logic        rst;
  logic        pixel_done, dsa_done;
  logic [15:0] current_x, current_y;
  logic        dsa_advance, capture_enable, step_ack, halted;
  logic [31:0] status;

  dsa_step_controller_if cmd_if ();

  dsa_step_controller #(.CNT_WIDTH(16)) dut (
    .clk            (clk),
    .rst            (rst),
    .cmd            (cmd_if),
    .pixel_done     (pixel_done),
    .dsa_done       (dsa_done),
    .current_x      (current_x),
    .current_y      (current_y),
    .dsa_advance    (dsa_advance),
    .capture_enable (capture_enable),
    .step_ack       (step_ack),
    .halted         (halted),
    .status         (status)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          cyc;
    logic [36:0] exp;
    string       name;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   now = 0;
  int   n_cmp = 0;
  int   n_fail = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: vector = {cmd_ready, step_ack, halted, dsa_advance, capture_enable, status}
  always @(negedge clk) begin
    logic [36:0] obs;
    exp_t e;
    obs = {cmd_if.cmd_ready, step_ack, halted, dsa_advance, capture_enable, status};
    while (q.size() > 0 && q[0].cyc <= cyc) begin
      e = q.pop_front();
      n_cmp++;
      if (obs !== e.exp) begin
        n_fail++;
        $display("FAIL %s cyc=%0d got=%h want=%h", e.name, cyc, obs, e.exp);
      end
    end
  end

  function automatic void ex(input int at, input bit ack, input bit hlt, input bit adv,
                             input bit cap, input logic [31:0] st, input string nm);
    exp_t e;
    e.cyc  = at;
    e.exp  = {1'b1, ack, hlt, adv, cap, st};
    e.name = nm;
    q.push_back(e);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
    now = cyc;
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    cmd_if.cmd_valid = 1'b1;
    cmd_if.cmd_addr  = a;
    cmd_if.cmd_wdata = d;
    tick();
    cmd_if.cmd_valid = 1'b0;
    cmd_if.cmd_addr  = 2'd0;
    cmd_if.cmd_wdata = 32'd0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog cyc=%0d expected finish earlier", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int b;
    rst = 1'b1;
    cmd_if.cmd_valid = 1'b0;
    cmd_if.cmd_addr  = 2'd0;
    cmd_if.cmd_wdata = 32'd0;
    pixel_done = 1'b0;
    dsa_done   = 1'b0;
    current_x  = 16'd0;
    current_y  = 16'd0;
    repeat (2) tick();
    rst = 1'b0;

    // Idle after reset
    for (int i = 0; i < 20; i++) ex(now + i, 0, 0, 1, 0, 32'h0, "reset_idle");
    repeat (20) tick();

    // Halt: debug_en + halt
    wr(2'd0, 32'h03); b = now;
    ex(b,     0, 0, 1, 1, 32'h0, "halt_accept");
    ex(b + 1, 1, 0, 0, 1, 32'h3, "halt_ack");
    ex(b + 2, 0, 1, 0, 1, 32'h1, "halted");
    ex(b + 3, 0, 1, 0, 1, 32'h1, "halted_hold");
    repeat (3) tick();

    // Step N=5 in cycle mode
    wr(2'd1, 32'd5);
    wr(2'd0, 32'h09); b = now;
    ex(b, 0, 1, 0, 1, 32'h1, "step5_pre");
    for (int i = 1; i <= 5; i++) ex(b + i, 0, 0, 1, 1, {16'(6 - i), 16'h0002}, "step5_run");
    ex(b + 6, 1, 0, 0, 1, 32'h3, "step5_ack");
    ex(b + 7, 0, 1, 0, 1, 32'h1, "step5_halted");
    repeat (7) tick();

    // Step with N=0 behaves as one cycle
    wr(2'd1, 32'd0);
    wr(2'd0, 32'h09); b = now;
    ex(b,     0, 1, 0, 1, 32'h1,        "step0_pre");
    ex(b + 1, 0, 0, 1, 1, 32'h00010002, "step0_run");
    ex(b + 2, 1, 0, 0, 1, 32'h3,        "step0_ack");
    ex(b + 3, 0, 1, 0, 1, 32'h1,        "step0_halted");
    repeat (3) tick();

    // Pixel-mode step, N=2
    wr(2'd1, 32'd2);
    wr(2'd0, 32'h19); b = now;
    ex(b,     0, 1, 0, 1, 32'h5,        "pix_pre");
    ex(b + 1, 0, 0, 1, 1, 32'h00020006, "pix_run2");
    ex(b + 2, 0, 0, 1, 1, 32'h00020006, "pix_run2");
    for (int i = 3; i <= 6; i++) ex(b + i, 0, 0, 1, 1, 32'h00010006, "pix_run1");
    ex(b + 7, 1, 0, 0, 1, 32'h7, "pix_ack");
    ex(b + 8, 0, 1, 0, 1, 32'h5, "pix_halted");
    for (int i = 1; i <= 8; i++) begin
      tick();
      pixel_done = (i == 2 || i == 6);
    end

    // Breakpoint at (10,4): resume with bp_en, miss at (10,5), hit at (10,4)
    wr(2'd2, 32'h0004000A);
    wr(2'd0, 32'h25); b = now;
    ex(b,     0, 1, 0, 1, 32'h1, "bp_pre");
    ex(b + 1, 0, 0, 1, 1, 32'h0, "bp_run");
    ex(b + 2, 0, 0, 1, 1, 32'h0, "bp_match_cycle");
    ex(b + 3, 1, 0, 0, 1, 32'hB, "bp_ack");
    ex(b + 4, 0, 1, 0, 1, 32'h9, "bp_halted");
    tick(); pixel_done = 1'b1; current_x = 16'd10; current_y = 16'd5;
    tick(); current_y = 16'd4;
    tick(); pixel_done = 1'b0; current_x = 16'd0; current_y = 16'd0;
    tick();

    // Clear bp_hit while halted
    wr(2'd0, 32'h41); b = now;
    ex(b,     0, 1, 0, 1, 32'h9, "clr_pre");
    ex(b + 1, 0, 1, 0, 1, 32'h1, "clr_done");
    ex(b + 2, 0, 1, 0, 1, 32'h1, "clr_hold");
    repeat (2) tick();

    // debug_en dropped mid-step: back to RUN, no ack, count kept
    wr(2'd1, 32'd10);
    wr(2'd0, 32'h09); b = now;
    ex(b,     0, 1, 0, 1, 32'h1,        "abort_pre");
    ex(b + 1, 0, 0, 1, 1, 32'h000A0002, "abort_step10");
    ex(b + 2, 0, 0, 1, 1, 32'h00090002, "abort_step9");
    ex(b + 3, 0, 0, 1, 0, 32'h00080002, "abort_dbg_off");
    ex(b + 4, 0, 0, 1, 0, 32'h00080000, "abort_run");
    ex(b + 5, 0, 0, 1, 0, 32'h00080000, "abort_run_hold");
    repeat (2) tick();
    wr(2'd0, 32'h00);
    repeat (2) tick();

    // dsa_done during a step
    wr(2'd0, 32'h03); b = now;
    ex(b,     0, 0, 1, 1, 32'h00080000, "done_halt_accept");
    ex(b + 1, 1, 0, 0, 1, 32'h00080003, "done_halt_ack");
    ex(b + 2, 0, 1, 0, 1, 32'h00080001, "done_halted");
    wr(2'd1, 32'd10);
    wr(2'd0, 32'h09); b = now;
    ex(b + 1, 0, 0, 1, 1, 32'h000A0002, "done_step");
    ex(b + 2, 1, 0, 0, 1, 32'h00090013, "done_ack");
    ex(b + 3, 0, 1, 0, 1, 32'h00090011, "done_halted_seen");
    tick(); dsa_done = 1'b1;
    tick(); dsa_done = 1'b0;
    tick();

    // Resume clears dsa_done_seen
    wr(2'd0, 32'h05); b = now;
    ex(b,     0, 1, 0, 1, 32'h00090011, "resume_pre");
    ex(b + 1, 0, 0, 1, 1, 32'h00090000, "resume_run");
    tick();

    // Reset in the middle of a step: no ack
    wr(2'd0, 32'h03); b = now;
    ex(b,     0, 0, 1, 1, 32'h00090000, "rst_halt_accept");
    ex(b + 1, 1, 0, 0, 1, 32'h00090003, "rst_halt_ack");
    ex(b + 2, 0, 1, 0, 1, 32'h00090001, "rst_halted");
    ex(b + 3, 0, 0, 1, 1, 32'h000A0002, "rst_step");
    tick();
    wr(2'd0, 32'h09);
    tick();
    tick();
    rst = 1'b1;
    ex(now,     0, 0, 1, 0, 32'h0, "rst_mid_step");
    ex(now + 1, 0, 0, 1, 0, 32'h0, "rst_no_ack");
    ex(now + 2, 0, 0, 1, 0, 32'h0, "rst_released");
    tick();
    rst = 1'b0;
    repeat (3) tick();

    n_cmp++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL queue_drain pending=%0d required=0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
